// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, sequencer states, instruction field positions and ALU operation encodings
package instr_sequencer_pkg;
    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ADDSUB = 4'h1,
        OP_MUL    = 4'h2,
        OP_LOGIC  = 4'h3,
        OP_LSH    = 4'h4,
        OP_RSH    = 4'h5,
        OP_CMP    = 4'h6,
        OP_LDI    = 4'h7,
        OP_LD     = 4'h8,
        OP_ST     = 4'h9,
        OP_JMP    = 4'hA,
        OP_BR     = 4'hB,
        OP_ILL_C  = 4'hC,
        OP_ILL_D  = 4'hD,
        OP_ILL_E  = 4'hE,
        OP_HALT   = 4'hF
    } opcode_t;
    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_FETCH2,
        S_LOAD,
        S_STORE,
        S_HALT
    } state_t;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int SUB_LSB = 0;
    localparam logic [6:0] OPN_BUS = 7'b1000000;
    // ALU opcodes 1..6 map to enable bit 6 plus one-hot bit (opcode-1)
    function automatic logic [6:0] alu_onehot(input opcode_t op);
        logic [3:0] idx;
        idx = op - 4'd1;
        return {1'b1, 6'b000001 << idx};
    endfunction
endpackage

// File: rtl/instr_branch_cond.sv
// instr_branch_cond: maps the BR sub field and ALU status flags to a take-branch decision
module instr_branch_cond (
    input  logic [2:0] sub,
    input  logic [5:0] status,
    output logic       take
);
    logic [7:0] cond;
    assign cond = {~status[0], status, 1'b1};
    assign take = cond[sub];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode sequencer driving the ALU and a word-addressed memory
// JMP/BR are decoded only when INSTR_SEQ_BRANCH_EN is defined; otherwise they are illegal opcodes
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [2:0]  operandIndex1,
    output logic [2:0]  operandIndex2,
    output logic [2:0]  resultsIndex,
    output logic [6:0]  operation,
    output logic [3:0]  params,
    output logic        readBus,
    output logic [15:0] din,
    input  logic [15:0] alu_dout,
    input  logic [5:0]  alu_status,
    output logic        halted,
    output logic        illegal_op
);
    state_t      state;
    opcode_t     op;
    logic [15:0] pc, instr, imm;
    logic        run, ext, take, is_alu, is_ext, is_bad, fetching, ldi_cyc, ld_done;

    assign op     = opcode_t'(instr[OPC_LSB +: 4]);
    assign is_alu = op inside {OP_ADDSUB, OP_MUL, OP_LOGIC, OP_LSH, OP_RSH, OP_CMP};
`ifdef INSTR_SEQ_BRANCH_EN
    assign is_ext = op inside {OP_LDI, OP_LD, OP_ST, OP_JMP, OP_BR};
    assign is_bad = op inside {OP_ILL_C, OP_ILL_D, OP_ILL_E};
`else
    assign is_ext = op inside {OP_LDI, OP_LD, OP_ST};
    assign is_bad = op inside {OP_JMP, OP_BR, OP_ILL_C, OP_ILL_D, OP_ILL_E};
`endif

    instr_branch_cond u_cond (
        .sub    (instr[SUB_LSB +: 3]),
        .status (alu_status),
        .take   (take)
    );

    // run holds off the first fetch until the cycle after reset release so outputs stay 0 in reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= 16'h0;
            imm   <= 16'h0;
            run   <= 1'b0;
            ext   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH: if (run && mem_ready) begin
                    instr <= mem_rdata;
                    pc    <= pc + 16'd1;
                    ext   <= 1'b0;
                    state <= S_EXEC;
                end
                S_EXEC: state <= (!ext && op == OP_HALT) ? S_HALT :
                                 (!ext && is_ext) ? S_FETCH2 : S_FETCH;
                S_FETCH2: if (mem_ready) begin
                    imm   <= mem_rdata;
                    pc    <= (op == OP_JMP || (op == OP_BR && take)) ? mem_rdata : pc + 16'd1;
                    ext   <= 1'b1;
                    state <= op == OP_LDI ? S_EXEC :
                             op == OP_LD  ? S_LOAD :
                             op == OP_ST  ? S_STORE : S_FETCH;
                end
                S_LOAD, S_STORE: if (mem_ready) state <= S_FETCH;
                default: ;
            endcase
        end
    end

    // ext marks the LDI write-back pass through EXEC that follows the extension fetch
    assign fetching      = (state == S_FETCH && run) || state == S_FETCH2;
    assign ldi_cyc       = state == S_EXEC && ext;
    assign ld_done       = state == S_LOAD && mem_ready;
    assign mem_rd        = fetching || state == S_LOAD;
    assign mem_wr        = state == S_STORE;
    assign mem_addr      = fetching ? pc : (state == S_LOAD || state == S_STORE) ? imm : 16'h0;
    assign mem_wdata     = mem_wr ? alu_dout : 16'h0;
    assign readBus       = ldi_cyc || ld_done;
    assign operation     = (state == S_EXEC && !ext && is_alu) ? alu_onehot(op) :
                           readBus ? OPN_BUS : 7'h0;
    assign din           = ldi_cyc ? imm : ld_done ? mem_rdata : 16'h0;
    assign resultsIndex  = instr[RD_LSB +: 3];
    assign operandIndex1 = instr[RS1_LSB +: 3];
    assign operandIndex2 = instr[RS2_LSB +: 3];
    assign params        = {1'b0, instr[SUB_LSB +: 3]};
    assign halted        = state == S_HALT;
    assign illegal_op    = state == S_EXEC && !ext && is_bad;
endmodule
